// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : control FSM for a multicycle RV32I-style datapath
// Revision 1.0
// ============================================================================
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [2:0] pc_sel,
  output logic       reg_write,
  output logic [2:0] reg_sel,
  output logic       alu_src,
  output logic       instr_done,
  output logic       trap,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_FETCH  = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_EXEC   = 3'b011;
  localparam logic [2:0] S_MEM    = 3'b100;
  localparam logic [2:0] S_WB     = 3'b101;
  localparam logic [2:0] S_TRAP   = 3'b110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [6:0] r_op;
  logic       w_legal;
  logic [2:0] w_after;
  logic       w_alu_imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 7'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: w_legal = 1'b1;
      default:                             w_legal = 1'b0;
    endcase
  end

  // Instruction boundary: continue only while run is held.
  assign w_after   = run ? S_FETCH : S_IDLE;
  assign w_alu_imm = !((r_op == OP_R) || (r_op == OP_BRANCH));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run || step) w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if ((r_op == OP_LOAD) || (r_op == OP_STORE)) w_next = S_MEM;
        else if (r_op == OP_BRANCH)                  w_next = w_after;
        else                                         w_next = S_WB;
      end
      S_MEM:    if (mem_ready) w_next = (r_op == OP_STORE) ? w_after : S_WB;
      S_WB:     w_next = w_after;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_iord   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 3'b000;
    reg_write  = 1'b0;
    reg_sel    = 3'b000;
    alu_src    = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        alu_src = w_alu_imm;
        if (r_op == OP_BRANCH) begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
          pc_sel     = branch_taken ? 3'b011 : 3'b000;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_iord = 1'b1;
        alu_src  = 1'b1;
        mem_we   = (r_op == OP_STORE);
        if ((r_op == OP_STORE) && mem_ready) begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        alu_src    = w_alu_imm;
        case (r_op)
          OP_LOAD:         reg_sel = 3'b001;
          OP_JAL, OP_JALR: reg_sel = 3'b000;
          OP_LUI:          reg_sel = 3'b100;
          OP_AUIPC:        reg_sel = 3'b011;
          default:         reg_sel = 3'b010;
        endcase
        if (r_op == OP_JAL)       pc_sel = 3'b011;
        else if (r_op == OP_JALR) pc_sel = 3'b010;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl : directed and randomized checks against a phase-list model.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_JR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1, run = 1'b0, step = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic mem_req, mem_we, mem_iord, ir_write, pc_write, reg_write, alu_src, instr_done, trap;
  logic [2:0] pc_sel, reg_sel, state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_iord(mem_iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write), .reg_sel(reg_sel),
    .alu_src(alu_src), .instr_done(instr_done), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  // Model: phase 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 wb, 6 trap.
  int         m_phase = 0;
  logic [6:0] m_op    = 7'd0;
  bit         m_valid = 0;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_JR, OP_BR, OP_LU, OP_AU, OP_J};
  endfunction

  // Phase following ph in this instruction's phase list, -1 at the end.
  function automatic int next_in_list(input int ph, input logic [6:0] op);
    int seq[$];
    if (op == OP_LD)      seq = '{1, 2, 3, 4, 5};
    else if (op == OP_ST) seq = '{1, 2, 3, 4};
    else if (op == OP_BR) seq = '{1, 2, 3};
    else                  seq = '{1, 2, 3, 5};
    foreach (seq[i])
      if (seq[i] == ph) return (i + 1 < seq.size()) ? seq[i + 1] : -1;
    return -1;
  endfunction

  function automatic logic [17:0] exp_out(input int ph, input logic [6:0] op,
                                          input bit bt, input bit mr);
    logic req = 0, we = 0, iord = 0, irw = 0, pcw = 0, rw = 0, alu = 0, done = 0, tr = 0;
    logic [2:0] pcs = 3'd0, rs = 3'd0;
    logic alu_imm;
    alu_imm = !(op == OP_R || op == OP_BR);
    case (ph)
      1: begin req = 1; irw = mr; end
      3: begin
        alu = alu_imm;
        if (op == OP_BR) begin pcw = 1; done = 1; pcs = bt ? 3'd3 : 3'd0; end
      end
      4: begin
        req = 1; iord = 1; alu = 1; we = (op == OP_ST);
        if (op == OP_ST && mr) begin pcw = 1; done = 1; end
      end
      5: begin
        rw = 1; pcw = 1; done = 1; alu = alu_imm;
        if (op == OP_LD) rs = 3'd1;
        else if (op == OP_J || op == OP_JR) rs = 3'd0;
        else if (op == OP_LU) rs = 3'd4;
        else if (op == OP_AU) rs = 3'd3;
        else rs = 3'd2;
        pcs = (op == OP_J) ? 3'd3 : (op == OP_JR) ? 3'd2 : 3'd0;
      end
      6: tr = 1;
      default: ;
    endcase
    return {req, we, iord, irw, pcw, pcs, rw, rs, alu, done, tr, 3'(ph)};
  endfunction

  task automatic model_advance();
    int n;
    if (rst) begin m_phase = 0; m_op = 7'd0; m_valid = 1; return; end
    case (m_phase)
      0: if (run || step) m_phase = 1;
      2: if (!is_legal(opcode)) m_phase = 6; else begin m_op = opcode; m_phase = 3; end
      6: ;
      default: begin
        if (!((m_phase == 1 || m_phase == 4) && !mem_ready)) begin
          n = next_in_list(m_phase, m_op);
          m_phase = (n < 0) ? (run ? 1 : 0) : n;
        end
      end
    endcase
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic cyc(input bit r, input bit ru, input bit st, input logic [6:0] op,
                     input bit bt, input bit mr);
    logic [17:0] got, exp;
    @(negedge clk);
    rst = r; run = ru; step = st; opcode = op; branch_taken = bt; mem_ready = mr;
    #1;
    cycle_no++;
    if (m_valid) begin
      got = {mem_req, mem_we, mem_iord, ir_write, pc_write, pc_sel, reg_write, reg_sel,
             alu_src, instr_done, trap, state};
      exp = exp_out(m_phase, m_op, bt, mr);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs cycle %0d phase %0d: got %h expected %h",
                 cycle_no, m_phase, got, exp);
      end
    end
    model_advance();
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, got, exp);
    end
  endtask

  initial begin
    logic [6:0] legal_ops [9];
    legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_JR, OP_BR, OP_LU, OP_AU, OP_J};

    // R-type back-to-back with zero-wait memory
    cyc(1, 0, 0, OP_R, 0, 1);
    cyc(0, 1, 0, OP_R, 0, 1);
    lit("reset_state", 32'(state), 0);
    lit("reset_outs", {mem_req, ir_write, pc_write, reg_write, instr_done, trap}, 0);
    cyc(0, 1, 0, OP_R, 0, 1); lit("r_fetch", 32'(state), 1);
    cyc(0, 1, 0, OP_R, 0, 1); lit("r_decode", 32'(state), 2);
    cyc(0, 1, 0, OP_R, 0, 1); lit("r_exec", 32'(state), 3);
    cyc(0, 1, 0, OP_R, 0, 1);
    lit("r_wb", {state, 1'b0, reg_write, reg_sel, pc_sel, instr_done}, {3'd5, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1});
    cyc(0, 1, 0, OP_R, 0, 1); lit("r_refetch", 32'(state), 1);

    // Load with two memory wait cycles
    cyc(1, 0, 0, OP_LD, 0, 1);
    cyc(0, 1, 0, OP_LD, 0, 1);
    cyc(0, 1, 0, OP_LD, 0, 1);
    cyc(0, 1, 0, OP_LD, 0, 1);
    cyc(0, 1, 0, OP_LD, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, OP_LD, 0, (i == 2));
      lit("ld_mem", {state, mem_req, mem_iord, mem_we}, {3'd4, 1'b1, 1'b1, 1'b0});
    end
    cyc(0, 1, 0, OP_LD, 0, 1); lit("ld_wb", {state, reg_sel}, {3'd5, 3'd1});

    // Single-stepped store
    cyc(1, 0, 0, OP_ST, 0, 1);
    cyc(0, 0, 1, OP_ST, 0, 1);
    cyc(0, 0, 0, OP_ST, 0, 1);
    cyc(0, 0, 0, OP_ST, 0, 1);
    cyc(0, 0, 0, OP_ST, 0, 1); lit("st_exec_we", 32'(mem_we), 0);
    cyc(0, 0, 0, OP_ST, 0, 1);
    lit("st_mem", {state, mem_we, reg_write, pc_write}, {3'd4, 1'b1, 1'b0, 1'b1});
    cyc(0, 0, 0, OP_ST, 0, 1); lit("st_idle", 32'(state), 0);
    cyc(0, 0, 0, OP_ST, 0, 1); lit("st_stay_idle", 32'(state), 0);

    // Taken branch via step
    cyc(1, 0, 0, OP_BR, 1, 1);
    cyc(0, 0, 1, OP_BR, 1, 1);
    cyc(0, 0, 0, OP_BR, 1, 1);
    cyc(0, 0, 0, OP_BR, 1, 1);
    cyc(0, 0, 0, OP_BR, 1, 1);
    lit("br_exec", {state, pc_write, pc_sel, reg_write}, {3'd3, 1'b1, 3'd3, 1'b0});
    cyc(0, 0, 0, OP_BR, 1, 1); lit("br_idle", 32'(state), 0);

    // Illegal opcode traps until reset
    cyc(1, 0, 0, OP_BAD, 0, 1);
    cyc(0, 1, 0, OP_BAD, 0, 1);
    cyc(0, 1, 0, OP_BAD, 0, 1);
    cyc(0, 1, 0, OP_BAD, 0, 1);
    cyc(0, 1, 1, OP_BAD, 0, 1); lit("trap_on", {state, trap}, {3'd6, 1'b1});
    cyc(0, 1, 1, OP_R, 0, 1);   lit("trap_sticky", {state, trap}, {3'd6, 1'b1});
    cyc(1, 1, 1, OP_R, 0, 1);
    cyc(0, 0, 0, OP_R, 0, 1);   lit("trap_cleared", {state, trap}, {3'd0, 1'b0});

    // Reset during a stalled data access
    cyc(1, 0, 0, OP_LD, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, OP_LD, 0, 1);
    cyc(1, 1, 0, OP_LD, 0, 0); lit("mem_before_rst", {state, mem_req}, {3'd4, 1'b1});
    cyc(0, 0, 0, OP_LD, 0, 0);
    lit("after_rst", {state, mem_req, pc_write, reg_write}, {3'd0, 1'b0, 1'b0, 1'b0});

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 99) < 90) ? legal_ops[$urandom_range(0, 8)] : 7'($urandom);
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 25), op, 1'($urandom), ($urandom_range(0, 99) < 65));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
